// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;
    localparam int DEF_NWR   = 2;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   addr_t;
    typedef logic [DEF_XLEN-1:0] data_t;

    // Width of an index selecting one of n items; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register write resolution: for each register, is it written this cycle
// and which write port supplies the value (highest-index enabled port wins).
// Register 0 is never reported as hit, so it can neither be written nor bypassed.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int NWR   = DEF_NWR,
    localparam int AW    = $clog2(NREGS),
    localparam int WIDX  = idx_bits(NWR)
) (
    input  logic [NWR-1:0]               write_en,
    input  logic [NWR-1:0][AW-1:0]       write_reg,
    output logic [NREGS-1:0]             hit,
    output logic [NREGS-1:0][WIDX-1:0]   win
);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign hit[gi] = 1'b0;
                assign win[gi] = '0;
            end else begin : g_arb
                logic            hit_c;
                logic [WIDX-1:0] win_c;

                // Scan ports in ascending order so a later (higher) match overrides.
                always_comb begin
                    hit_c = 1'b0;
                    win_c = '0;
                    for (int w = 0; w < NWR; w++) begin
                        if (write_en[w] && (write_reg[w] == AW'(gi))) begin
                            hit_c = 1'b1;
                            win_c = WIDX'(w);
                        end
                    end
                end

                assign hit[gi] = hit_c;
                assign win[gi] = win_c;
            end
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a writeback scoreboard (busy bit per register).
// Combinational reads, one-cycle writes, register 0 hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN -- a read of a register written in
// the same cycle returns the winning write data and busy reflects only a
// same-cycle reserve.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = DEF_NRD,
    parameter  int NWR   = DEF_NWR,
    localparam int AW    = $clog2(NREGS),
    localparam int WIDX  = idx_bits(NWR)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NRD-1:0][AW-1:0]       read_reg,
    output logic [NRD-1:0][XLEN-1:0]     read_data,
    output logic [NRD-1:0]               read_busy,
    input  logic [NWR-1:0]               write_en,
    input  logic [NWR-1:0][AW-1:0]       write_reg,
    input  logic [NWR-1:0][XLEN-1:0]     write_data,
    input  logic                         resv_en,
    input  logic [AW-1:0]                resv_reg,
    output logic [NREGS-1:0]             busy_vec
);

    logic [XLEN-1:0]             regs_reg [NREGS];
    logic [NREGS-1:0]            busy_reg;
    logic [NREGS-1:0]            wr_hit;
    logic [NREGS-1:0][WIDX-1:0]  wr_win;
    logic [NREGS-1:0][XLEN-1:0]  wr_data_win;

    regfile_wr_arb #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_wr_arb (
        .write_en  (write_en),
        .write_reg (write_reg),
        .hit       (wr_hit),
        .win       (wr_win)
    );

    genvar gi;
    generate
        // Value each register would take if written this cycle.
        for (gi = 0; gi < NREGS; gi++) begin : g_wdata
            assign wr_data_win[gi] = write_data[wr_win[gi]];
        end
    endgenerate

    // Storage and scoreboard update; a reserve beats a write-clear on the same register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_hit[i]) begin
                    regs_reg[i] <= wr_data_win[i];
                end
                if (resv_en && (resv_reg == AW'(i))) begin
                    busy_reg[i] <= 1'b1;
                end else if (wr_hit[i]) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy_reg;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [XLEN-1:0] data_c;
            logic            busy_c;

            // Read port: stored state, optionally overridden by a same-cycle write.
            always_comb begin
                data_c = regs_reg[read_reg[gi]];
                busy_c = busy_reg[read_reg[gi]];
`ifdef REGFILE_BYPASS_EN
                if (wr_hit[read_reg[gi]]) begin
                    data_c = wr_data_win[read_reg[gi]];
                    busy_c = resv_en && (resv_reg == read_reg[gi]);
                end
`endif
            end

            assign read_data[gi] = data_c;
            assign read_busy[gi] = busy_c;
        end
    endgenerate

endmodule
